// File: rtl/vc_mux_arbiter_if.sv
// Signal bundle between the VC0/VC1 FIFOs, the VC merge arbiter and the downstream FIFO.
// The master modport is the arbiter side; slave is the FIFO/downstream side.
interface vc_mux_arbiter_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  vc0_empty;
  logic                  vc1_empty;
  logic [DATA_WIDTH-1:0] data_in_vc0;
  logic [DATA_WIDTH-1:0] data_in_vc1;
  logic                  downstream_almost_full;
  logic                  pop_vc0;
  logic                  pop_vc1;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  vc_error;

  modport master (
    input  vc0_empty,
    input  vc1_empty,
    input  data_in_vc0,
    input  data_in_vc1,
    input  downstream_almost_full,
    output pop_vc0,
    output pop_vc1,
    output data_out,
    output valid_out,
    output vc_error
  );

  modport slave (
    output vc0_empty,
    output vc1_empty,
    output data_in_vc0,
    output data_in_vc1,
    output downstream_almost_full,
    input  pop_vc0,
    input  pop_vc1,
    input  data_out,
    input  valid_out,
    input  vc_error
  );
endinterface

// File: rtl/vc_mux_arbiter.sv
// Merges the VC0/VC1 FIFOs into one stream: combinational pop arbitration (round-robin or
// strict VC0 priority), two-cycle pop-to-output pipeline and a sticky VC tag mismatch flag.
module vc_mux_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter bit ARB_MODE   = 1'b1
) (
  input logic                clk,
  input logic                reset,
  vc_mux_arbiter_if.master   bus
);

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_t;

  vc_t                   rr_last;
  vc_t                   rd_sel;
  logic                  rd_pending;
  logic                  grant_vc0;
  logic                  grant_vc1;
  logic [DATA_WIDTH-1:0] captured;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_out_q;
  logic                  vc_error_q;

  // Grant: never during reset or downstream backpressure, never onto an empty FIFO.
  always_comb begin
    grant_vc0 = 1'b0;
    grant_vc1 = 1'b0;
    if (!reset && !bus.downstream_almost_full) begin
      if (!bus.vc0_empty && !bus.vc1_empty) begin
        if (!ARB_MODE || rr_last == VC1) begin
          grant_vc0 = 1'b1;
        end else begin
          grant_vc1 = 1'b1;
        end
      end else if (!bus.vc0_empty) begin
        grant_vc0 = 1'b1;
      end else if (!bus.vc1_empty) begin
        grant_vc1 = 1'b1;
      end
    end
  end

  assign bus.pop_vc0 = grant_vc0;
  assign bus.pop_vc1 = grant_vc1;

  always_comb begin
    captured = '0;
    if (rd_sel == VC1) begin
      captured = bus.data_in_vc1;
    end else begin
      captured = bus.data_in_vc0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last     <= VC1;
      rd_sel      <= VC0;
      rd_pending  <= 1'b0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      vc_error_q  <= 1'b0;
    end else begin
      rd_pending <= grant_vc0 | grant_vc1;
      if (grant_vc0 || grant_vc1) begin
        rd_sel <= grant_vc1 ? VC1 : VC0;
        if (ARB_MODE) begin
          rr_last <= grant_vc1 ? VC1 : VC0;
        end
      end

      // FIFO read data is valid the cycle after the pop, so capture on rd_pending.
      if (rd_pending) begin
        data_out_q  <= captured;
        valid_out_q <= 1'b1;
        if (captured[DATA_WIDTH-1] != rd_sel) begin
          vc_error_q <= 1'b1;
        end
      end else begin
        data_out_q  <= '0;
        valid_out_q <= 1'b0;
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.vc_error  = vc_error_q;

endmodule
